// File: rtl/sw_alloc.sv
// Switch allocator: per-output round-robin arbitration among rx inputs,
// with each grant held for the whole packet until the owner drops sw_req.
module sw_alloc #(
   parameter int NPORTS = 5,
   parameter int CHW    = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NPORTS-1:0]        sw_req,
   input  logic [NPORTS*CHW-1:0]    sw_chnl,
   input  logic [NPORTS-1:0]        out_busy,
   output logic [NPORTS-1:0]        sw_gnt,
   output logic [NPORTS*CHW-1:0]    xbar_sel,
   output logic [NPORTS-1:0]        xbar_vld,
   output logic                     bad_chnl
);

   typedef enum logic {IDLE, LOCKED} st_e;

   st_e [NPORTS-1:0]             st_q, st_d;
   logic [NPORTS-1:0][CHW-1:0]   sel_q, sel_d;
   logic [NPORTS-1:0][CHW-1:0]   ptr_q, ptr_d;
   logic [NPORTS-1:0]            gnt_q, gnt_d;
   logic                         bad_q, bad_d;
   logic                         found;
   int                           win;
   int                           cand;
   logic                         multi_own;
   int                           own_cnt;

   always_comb begin
      st_d  = st_q;
      sel_d = sel_q;
      ptr_d = ptr_q;
      gnt_d = gnt_q;
      bad_d = bad_q;
      found = 1'b0;
      win   = 0;
      cand  = 0;
      for (int i = 0; i < NPORTS; i++) begin
         if (sw_req[i] && (32'(sw_chnl[i*CHW +: CHW]) >= NPORTS))
            bad_d = 1'b1;
      end
      for (int o = 0; o < NPORTS; o++) begin
         found = 1'b0;
         win   = 0;
         if (st_q[o] == LOCKED) begin
            // channel and backpressure are ignored once the packet owns the output
            if (!sw_req[sel_q[o]]) begin
               st_d[o]           = IDLE;
               gnt_d[sel_q[o]]   = 1'b0;
            end
         end else if (!out_busy[o]) begin
            for (int k = 1; k <= NPORTS; k++) begin
               cand = (int'(ptr_q[o]) + k) % NPORTS;
               if (!found && sw_req[cand] && !gnt_q[cand] &&
                   (sw_chnl[cand*CHW +: CHW] == CHW'(o))) begin
                  found = 1'b1;
                  win   = cand;
               end
            end
            if (found) begin
               st_d[o]    = LOCKED;
               sel_d[o]   = CHW'(win);
               ptr_d[o]   = CHW'(win);
               gnt_d[win] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int o = 0; o < NPORTS; o++) begin
            st_q[o]  <= IDLE;
            sel_q[o] <= '0;
            ptr_q[o] <= CHW'(NPORTS-1);
         end
         gnt_q <= '0;
         bad_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         sel_q <= sel_d;
         ptr_q <= ptr_d;
         gnt_q <= gnt_d;
         bad_q <= bad_d;
      end
   end

   // an input may be owned by at most one output at a time
   always_comb begin
      multi_own = 1'b0;
      own_cnt   = 0;
      for (int i = 0; i < NPORTS; i++) begin
         own_cnt = 0;
         for (int o = 0; o < NPORTS; o++) begin
            if ((st_q[o] == LOCKED) && (sel_q[o] == CHW'(i)))
               own_cnt = own_cnt + 1;
         end
         if (own_cnt > 1)
            multi_own = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         assert (!multi_own) else $error("input owned by two outputs");
   end

   always_comb begin
      for (int o = 0; o < NPORTS; o++)
         xbar_vld[o] = (st_q[o] == LOCKED);
   end

   assign sw_gnt   = gnt_q;
   assign xbar_sel = sel_q;
   assign bad_chnl = bad_q;

endmodule

// File: tb/tb_sw_alloc.sv
// Directed scoreboard bench for sw_alloc: expected state is queued when
// stimulus is applied and compared one cycle later.
module tb_sw_alloc;

   localparam int N = 5;
   localparam int W = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   sw_req;
   logic [N*W-1:0] sw_chnl;
   logic [N-1:0]   out_busy;
   logic [N-1:0]   sw_gnt;
   logic [N*W-1:0] xbar_sel;
   logic [N-1:0]   xbar_vld;
   logic           bad_chnl;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string          tag;
      logic [N-1:0]   g;
      logic [N-1:0]   v;
      logic [N*W-1:0] s;
      logic [N*W-1:0] m;
      logic           b;
   } exp_t;

   exp_t sb[$];

   sw_alloc #(.NPORTS(N), .CHW(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .sw_req   (sw_req),
      .sw_chnl  (sw_chnl),
      .out_busy (out_busy),
      .sw_gnt   (sw_gnt),
      .xbar_sel (xbar_sel),
      .xbar_vld (xbar_vld),
      .bad_chnl (bad_chnl)
   );

   always #5 clk = ~clk;

   function automatic logic [N*W-1:0] sv(int o, int w);
      logic [N*W-1:0] r;
      r = '0;
      r[o*W +: W] = W'(w);
      return r;
   endfunction

   function automatic logic [N*W-1:0] mk(int o);
      logic [N*W-1:0] r;
      r = '0;
      r[o*W +: W] = '1;
      return r;
   endfunction

   task automatic setc(int i, int c);
      sw_chnl[i*W +: W] = W'(c);
   endtask

   task automatic check();
      exp_t e;
      n_chk++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL sb_empty got 0 entries want 1");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         assert (sw_gnt === e.g) else begin
            n_fail++;
            $error("FAIL %s gnt got %b want %b", e.tag, sw_gnt, e.g);
         end
         n_chk++;
         assert (xbar_vld === e.v) else begin
            n_fail++;
            $error("FAIL %s vld got %b want %b", e.tag, xbar_vld, e.v);
         end
         n_chk++;
         assert ((xbar_sel & e.m) === e.s) else begin
            n_fail++;
            $error("FAIL %s sel got %h want %h", e.tag, xbar_sel & e.m, e.s);
         end
         n_chk++;
         assert (bad_chnl === e.b) else begin
            n_fail++;
            $error("FAIL %s bad got %b want %b", e.tag, bad_chnl, e.b);
         end
      end
   endtask

   task automatic step(string tag, logic [N-1:0] g, logic [N-1:0] v,
                       logic [N*W-1:0] s, logic [N*W-1:0] m, logic b);
      exp_t e;
      e.tag = tag; e.g = g; e.v = v; e.s = s; e.m = m; e.b = b;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check();
   endtask

   int owners[4] = '{0, 1, 3, 0};

   initial begin
      reset    = 1'b1;
      sw_req   = '0;
      sw_chnl  = '0;
      out_busy = '0;
      step("reset", 5'b0, 5'b0, '0, '1, 1'b0);
      reset = 1'b0;

      // single packet on output 4
      sw_req[2] = 1'b1; setc(2, 4);
      step("t1_gnt", 5'b00100, 5'b10000, sv(4, 2), mk(4), 1'b0);
      for (int c = 0; c < 10; c++)
         step("t1_hold", 5'b00100, 5'b10000, sv(4, 2), mk(4), 1'b0);
      sw_req[2] = 1'b0;
      step("t1_rel", 5'b0, 5'b0, sv(4, 2), mk(4), 1'b0);

      // three inputs sharing output 1, rr order 0,1,3,0
      setc(0, 1); setc(1, 1); setc(3, 1);
      sw_req[0] = 1'b1; sw_req[1] = 1'b1; sw_req[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 3; c++)
            step("t2_own", 5'(1 << owners[k]), 5'b00010,
                 sv(1, owners[k]), mk(1), 1'b0);
         sw_req[owners[k]] = 1'b0;
         step("t2_gap", 5'b0, 5'b0, sv(1, owners[k]), mk(1), 1'b0);
         sw_req[owners[k]] = 1'b1;
      end
      sw_req = '0;
      step("t2_idle", 5'b0, 5'b0, '0, '0, 1'b0);

      // independent outputs grant on the same edge
      setc(0, 2); setc(1, 3);
      sw_req[0] = 1'b1; sw_req[1] = 1'b1;
      step("t3_both", 5'b00011, 5'b01100, sv(2, 0) | sv(3, 1),
           mk(2) | mk(3), 1'b0);
      sw_req = '0;
      step("t3_rel", 5'b0, 5'b0, '0, '0, 1'b0);

      // backpressure blocks allocation only while idle
      out_busy[2] = 1'b1;
      setc(4, 2); sw_req[4] = 1'b1;
      step("t4_busy", 5'b0, 5'b0, '0, '0, 1'b0);
      step("t4_busy", 5'b0, 5'b0, '0, '0, 1'b0);
      out_busy[2] = 1'b0;
      step("t4_gnt", 5'b10000, 5'b00100, sv(2, 4), mk(2), 1'b0);
      out_busy[2] = 1'b1;
      step("t4_lockb", 5'b10000, 5'b00100, sv(2, 4), mk(2), 1'b0);
      step("t4_lockb", 5'b10000, 5'b00100, sv(2, 4), mk(2), 1'b0);
      sw_req = '0; out_busy = '0;
      step("t4_rel", 5'b0, 5'b0, sv(2, 4), mk(2), 1'b0);

      // invalid channel is never granted, flag is sticky
      setc(1, 6); sw_req[1] = 1'b1;
      step("t5_bad", 5'b0, 5'b0, '0, '0, 1'b1);
      sw_req = '0;
      step("t5_stick", 5'b0, 5'b0, '0, '0, 1'b1);
      step("t5_stick", 5'b0, 5'b0, '0, '0, 1'b1);

      // reset mid-packet, then rr pointer restarts at input 0
      setc(0, 0); setc(2, 3);
      sw_req[0] = 1'b1; sw_req[2] = 1'b1;
      step("t6_pre", 5'b00101, 5'b01001, sv(0, 0) | sv(3, 2),
           mk(0) | mk(3), 1'b1);
      setc(2, 0);
      reset = 1'b1;
      step("t6_rst", 5'b0, 5'b0, '0, '1, 1'b0);
      reset = 1'b0;
      step("t6_w0", 5'b00001, 5'b00001, sv(0, 0), mk(0), 1'b0);
      sw_req[0] = 1'b0;
      step("t6_rel", 5'b0, 5'b0, sv(0, 0), mk(0), 1'b0);
      step("t6_w2", 5'b00100, 5'b00001, sv(0, 2), mk(0), 1'b0);
      sw_req = '0;
      step("t6_end", 5'b0, 5'b0, sv(0, 2), mk(0), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
